// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the CPU front end.
//   WORD_W            : data/address word width
//   DEFAULT_RESET_PC  : default word-indexed fetch address after reset
//   fetch_entry_t     : one fetched {pc, inst} pair as buffered for decode
//   fill_state_e      : occupancy class of a queue (EMPTY / PARTIAL / FULL)
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_FULL    = 2'd2
    } fill_state_e;

    // Classify a queue occupancy; the queue has no state beyond its count.
    function automatic fill_state_e fill_state(input int unsigned count,
                                               input int unsigned depth);
        fill_state_e st;
        st = FILL_PARTIAL;
        if (count == 0) begin
            st = FILL_EMPTY;
        end else if (count >= depth) begin
            st = FILL_FULL;
        end
        return st;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// Bundles the fetch stage's memory, redirect and decode handshake signals.
//   pc             : word address to instruction memory (fetch -> memory)
//   inst_in        : instruction word for the current pc (memory -> fetch)
//   redirect_valid : redirect request from execute
//   redirect_pc    : redirect target word address
//   dec_valid      : decode-side head valid
//   dec_ready      : decode accepts the head this cycle
//   dec_inst       : head instruction, 0 when not valid
//   dec_pc         : head word address, 0 when not valid
// master = fetch stage, slave = surrounding memory / execute / decode.
// ---------------------------------------------------------------------------
interface inst_fetch_if;
    import cpu_pkg::*;

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst_in;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [WORD_W-1:0] dec_inst;
    logic [WORD_W-1:0] dec_pc;

    modport master (
        output pc,
        input  inst_in,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_inst,
        output dec_pc
    );

    modport slave (
        input  pc,
        output inst_in,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_inst,
        input  dec_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of entry_t with synchronous flush. A push is accepted
// when not full, or when a pop happens in the same cycle. Flush wins over
// push and pop.
//   clk, rst : clock, synchronous active-high reset
//   push     : enqueue wdata
//   wdata    : entry to enqueue
//   pop      : dequeue head (ignored when empty)
//   flush    : drop all entries
//   rdata    : head entry (stale contents when empty)
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of valid entries
// DEPTH must be a power of 2 and at least 2.
// ---------------------------------------------------------------------------
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;
    fill_state_e        fill_st;

    // Occupancy class drives the full/empty flags.
    always_comb begin
        fill_st = fill_state(32'(count_q), DEPTH);
    end

    // Pointer and count next-state; pointers wrap naturally (power-of-2 depth).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (fill_st != FILL_EMPTY);
        do_push = push && ((fill_st != FILL_FULL) || do_pop);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem_q[tail_q] <= wdata;
        end
    end

    assign rdata = mem_q[head_q];
    assign full  = (fill_st == FILL_FULL);
    assign empty = (fill_st == FILL_EMPTY);
    assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage. Holds the word-indexed fetch PC, captures the
// combinational memory response into a small queue as {pc, inst} pairs and
// presents the queue head to decode over valid/ready. A redirect flushes
// the queue and reloads the PC.
//   RESET_PC : fetch word address after reset
//   QDEPTH   : queue entries (power of 2, >= 2)
//   clk      : clock
//   rst      : synchronous active-high reset
//   bus      : inst_fetch_if.master (pc/inst_in, redirect, decode handshake)
// ---------------------------------------------------------------------------
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned       QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              pop;
    logic              push;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Handshake and fetch-accept decisions. A pop frees a slot, so a full
    // queue still takes the new fetch in the same cycle.
    always_comb begin
        pop  = !fifo_empty && bus.dec_ready;
        push = !bus.redirect_valid && (!fifo_full || pop);
    end

    // PC next-state: redirect beats sequential advance; otherwise hold and
    // re-read the same address.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + WORD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign wr_entry = '{pc: fetch_pc_q, inst: bus.inst_in};

    fetch_fifo #(
        .DEPTH   (QDEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy must stay within the queue and agree with the empty flag.
    a_count_sane: assert property (@(posedge clk) disable iff (rst)
        (fifo_count <= CNT_W'(QDEPTH)) && (fifo_empty == (fifo_count == '0)));

    // Outputs: PC straight from its register, decode payload zero-gated.
    assign bus.pc        = fetch_pc_q;
    assign bus.dec_valid = !fifo_empty;
    assign bus.dec_inst  = fifo_empty ? '0 : head_entry.inst;
    assign bus.dec_pc    = fifo_empty ? '0 : head_entry.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Directed scenarios followed by random redirect/stall/reset traffic, all
// checked against a queue-based model of the fetch stage. A second instance
// with RESET_PC near the top of the address space checks PC wrap.
// ---------------------------------------------------------------------------
module tb_inst_fetch;
    import cpu_pkg::*;

    localparam logic [31:0] RPC_A = 32'h0000_0010;
    localparam logic [31:0] RPC_W = 32'hFFFF_FFFE;
    localparam int unsigned QD    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    inst_fetch_if ifa();
    inst_fetch_if ifw();

    // Instruction memory: word i holds 0xA000_0000 + i.
    assign ifa.inst_in = 32'hA000_0000 + ifa.pc;
    assign ifw.inst_in = 32'hA000_0000 + ifw.pc;

    inst_fetch #(.RESET_PC(RPC_A), .QDEPTH(QD)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    inst_fetch #(.RESET_PC(RPC_W), .QDEPTH(QD)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (ifw)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: next fetch address and the queue of buffered PCs.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    int unsigned wcyc;
    bit          wrap_chk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle: check current outputs, drive this cycle's inputs, advance model.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc,
                        input logic rdy);
        bit          v;
        bit          pop;
        bit          room;
        logic [31:0] e_pc;
        logic [31:0] e_inst;

        @(negedge clk);
        v      = (m_q.size() != 0);
        e_pc   = 32'h0;
        e_inst = 32'h0;
        if (v) begin
            e_pc   = m_q[0];
            e_inst = 32'hA000_0000 + m_q[0];
        end
        check_val("pc",        ifa.pc,             m_pc);
        check_val("dec_valid", 32'(ifa.dec_valid), 32'(v));
        check_val("dec_pc",    ifa.dec_pc,         e_pc);
        check_val("dec_inst",  ifa.dec_inst,       e_inst);

        if (wrap_chk) begin
            if (wcyc == 0) begin
                check_val("wrap_pc0",    ifw.pc,             RPC_W);
                check_val("wrap_valid0", 32'(ifw.dec_valid), 32'h0);
            end else if (wcyc <= 4) begin
                check_val("wrap_valid",  32'(ifw.dec_valid), 32'h1);
                check_val("wrap_dec_pc", ifw.dec_pc,         RPC_W + 32'(wcyc - 1));
            end
        end
        wcyc++;

        rst                = r;
        ifa.redirect_valid = rv;
        ifa.redirect_pc    = rpc;
        ifa.dec_ready      = rdy;

        if (r) begin
            m_pc = RPC_A;
            m_q.delete();
        end else begin
            pop = v && rdy;
            if (rv) begin
                m_q.delete();
                m_pc = rpc;
            end else begin
                room = (m_q.size() < QD) || pop;
                if (pop) void'(m_q.pop_front());
                if (room) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd1;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rpc;
        ifa.redirect_valid = 1'b0;
        ifa.redirect_pc    = 32'h0;
        ifa.dec_ready      = 1'b0;
        ifw.redirect_valid = 1'b0;
        ifw.redirect_pc    = 32'h0;
        ifw.dec_ready      = 1'b1;
        rst                = 1'b1;
        repeat (2) @(posedge clk);
        m_pc = RPC_A;
        m_q.delete();
        wcyc     = 0;
        wrap_chk = 1'b1;

        // Free-running decode from reset (also drives the wrap instance check).
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
        wrap_chk = 1'b0;

        // Stall from reset until full, then drain with simultaneous push/pop.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect while three entries are queued and decode is ready.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset with two entries queued.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFFC + 32'($urandom_range(3));
            else                        rpc = $urandom;
            step(1'b0 || ($urandom_range(59) == 0),
                 ($urandom_range(7) == 0),
                 rpc,
                 ($urandom_range(2) != 0));
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
